// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the pipelined LC-3b datapath.
// Produces per-operand forwarding selects, load-use bubbles, memory-wait
// freezes and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int NUM_SRC      = 2,
    parameter int REG_W        = 3,
    parameter int NUM_FWD      = 2,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 16,
    parameter int SEL_W        = $clog2(NUM_FWD + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid,
    input  logic [NUM_SRC*REG_W-1:0]   ex_src,
    input  logic [NUM_SRC-1:0]         ex_src_valid,
    input  logic [NUM_FWD*REG_W-1:0]   fwd_dest,
    input  logic [NUM_FWD-1:0]         fwd_load,
    input  logic                       mem_read_mem,
    input  logic                       mem_access,
    input  logic                       mem_resp,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stall_load,
    output logic                       stall_mem,
    output logic [CNT_W-1:0]           stall_count
);

    localparam int BCNT_W = $clog2(LOAD_BUBBLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t              state;
    logic [BCNT_W-1:0]   bcnt;
    logic                src_hit;
    logic                luh;

    // Forwarding select: youngest matching stage wins, 0 selects the regfile.
    always_comb begin
        // NOTE: default every output first so no path through the loops leaves
        // a bit unassigned, which would otherwise infer a latch.
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Scan oldest to youngest so the smallest matching k is written last.
            for (int k = NUM_FWD; k >= 1; k--) begin
                if (ex_src_valid[i] && fwd_load[k-1] &&
                    ex_src[i*REG_W +: REG_W] == fwd_dest[(k-1)*REG_W +: REG_W])
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
            end
        end
    end

    // Does any read operand of EX need the destination of the MEM stage.
    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_src_valid[i] && ex_src[i*REG_W +: REG_W] == fwd_dest[0 +: REG_W])
                src_hit = 1'b1;
        end
    end

    assign luh = ex_valid & mem_read_mem & fwd_load[0] & src_hit;

    // Memory wait dominates; a bubble is only requested while not frozen.
    // Both are masked by reset so they drop without waiting for a clock edge.
    assign stall_mem  = ~rst & mem_access & ~mem_resp;
    assign stall_load = ~rst & ~stall_mem & ((state == BUBBLE) | luh);

    // Bubble sequencer: the detection cycle is the first bubble, BUBBLE adds the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            bcnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            case (state)
                RUN: begin
                    if (stall_load && LOAD_BUBBLES > 1) begin
                        state <= BUBBLE;
                        bcnt  <= BCNT_W'(LOAD_BUBBLES - 1);
                    end
                end
                BUBBLE: begin
                    if (!stall_mem) begin
                        bcnt <= bcnt - 1'b1;
                        if (bcnt == BCNT_W'(1))
                            state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    bcnt  <= '0;
                end
            endcase
        end
    end

    // Saturating count of every cycle in which the pipeline was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if ((stall_load || stall_mem) && stall_count != CNT_MAX)
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three instances share stimulus
// (LOAD_BUBBLES=1, LOAD_BUBBLES=3, CNT_W=4); expectations go through a
// scoreboard queue drained on the falling clock edge.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       ex_valid;
    logic [5:0] ex_src;
    logic [1:0] ex_src_valid;
    logic [5:0] fwd_dest;
    logic [1:0] fwd_load;
    logic       mem_read_mem;
    logic       mem_access;
    logic       mem_resp;

    logic [3:0]  fwd_sel_a, fwd_sel_b, fwd_sel_c;
    logic        stall_load_a, stall_load_b, stall_load_c;
    logic        stall_mem_a, stall_mem_b, stall_mem_c;
    logic [15:0] stall_count_a, stall_count_b;
    logic [3:0]  stall_count_c;

    hazard_ctrl #(.LOAD_BUBBLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_src(ex_src),
        .ex_src_valid(ex_src_valid), .fwd_dest(fwd_dest), .fwd_load(fwd_load),
        .mem_read_mem(mem_read_mem), .mem_access(mem_access), .mem_resp(mem_resp),
        .fwd_sel(fwd_sel_a), .stall_load(stall_load_a), .stall_mem(stall_mem_a),
        .stall_count(stall_count_a)
    );

    hazard_ctrl #(.LOAD_BUBBLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_src(ex_src),
        .ex_src_valid(ex_src_valid), .fwd_dest(fwd_dest), .fwd_load(fwd_load),
        .mem_read_mem(mem_read_mem), .mem_access(mem_access), .mem_resp(mem_resp),
        .fwd_sel(fwd_sel_b), .stall_load(stall_load_b), .stall_mem(stall_mem_b),
        .stall_count(stall_count_b)
    );

    hazard_ctrl #(.CNT_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_src(ex_src),
        .ex_src_valid(ex_src_valid), .fwd_dest(fwd_dest), .fwd_load(fwd_load),
        .mem_read_mem(mem_read_mem), .mem_access(mem_access), .mem_resp(mem_resp),
        .fwd_sel(fwd_sel_c), .stall_load(stall_load_c), .stall_mem(stall_mem_c),
        .stall_count(stall_count_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         dut;
        logic [3:0] sel;
        logic       sl;
        logic       sm;
        int         cnt;
    } exp_t;

    typedef struct {
        logic [5:0] src;
        logic [1:0] srcv;
        logic [5:0] dest;
        logic [1:0] load;
        logic [3:0] sel;
    } fwd_vec_t;

    exp_t     sb_q[$];
    exp_t     e_cur;
    fwd_vec_t fwd_tbl[8];
    logic [21:0] act;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input int dut, input logic [3:0] sel,
                        input logic sl, input logic sm, input int cnt);
        exp_t e;
        e.name = name; e.dut = dut; e.sel = sel; e.sl = sl; e.sm = sm; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    task automatic set_in(input logic ev, input logic [5:0] src, input logic [1:0] srcv,
                          input logic [5:0] dest, input logic [1:0] load,
                          input logic mrm, input logic ma, input logic mr);
        ex_valid = ev; ex_src = src; ex_src_valid = srcv; fwd_dest = dest;
        fwd_load = load; mem_read_mem = mrm; mem_access = ma; mem_resp = mr;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
    endtask

    // Scoreboard drain: compare every pending expectation mid-cycle.
    always @(negedge clk) begin
        while (sb_q.size() != 0) begin
            e_cur = sb_q.pop_front();
            case (e_cur.dut)
                0:       act = {fwd_sel_a, stall_load_a, stall_mem_a, stall_count_a};
                1:       act = {fwd_sel_b, stall_load_b, stall_mem_b, stall_count_b};
                default: act = {fwd_sel_c, stall_load_c, stall_mem_c, 12'b0, stall_count_c};
            endcase
            check(e_cur.name, {10'b0, act},
                  {10'b0, e_cur.sel, e_cur.sl, e_cur.sm, 16'(e_cur.cnt)});
        end
    end

    initial begin
        // {src, srcv, dest, load, sel}; operand 1 / stage 2 in the high octal digit.
        fwd_tbl[0] = '{6'o33, 2'b11, 6'o33, 2'b11, 4'b0101};
        fwd_tbl[1] = '{6'o33, 2'b11, 6'o33, 2'b10, 4'b1010};
        fwd_tbl[2] = '{6'o33, 2'b01, 6'o33, 2'b10, 4'b0010};
        fwd_tbl[3] = '{6'o21, 2'b11, 6'o43, 2'b11, 4'b0000};
        fwd_tbl[4] = '{6'o42, 2'b11, 6'o24, 2'b11, 4'b0110};
        fwd_tbl[5] = '{6'o42, 2'b11, 6'o24, 2'b00, 4'b0000};
        fwd_tbl[6] = '{6'o70, 2'b10, 6'o07, 2'b11, 4'b0100};
        fwd_tbl[7] = '{6'o55, 2'b11, 6'o05, 2'b10, 4'b0000};

        // Reset: stalls forced low even with a pending memory access.
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        step();
        push("reset_a", 0, 4'b0, 0, 0, 0);
        push("reset_b", 1, 4'b0, 0, 0, 0);
        push("reset_c", 2, 4'b0, 0, 0, 0);
        step();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);

        // Forwarding priority table.
        for (int i = 0; i < 8; i++) begin
            step();
            set_in(0, fwd_tbl[i].src, fwd_tbl[i].srcv, fwd_tbl[i].dest, fwd_tbl[i].load, 0, 0, 0);
            push($sformatf("fwd_vec%0d", i), 0, fwd_tbl[i].sel, 0, 0, 0);
        end

        // Single bubble, load writing R5 then moving to WB.
        do_reset();
        step();
        set_in(1, 6'o05, 2'b01, 6'o05, 2'b01, 1, 0, 0);
        push("sb_detect", 0, 4'b0001, 1, 0, 0);
        step();
        set_in(1, 6'o05, 2'b01, 6'o50, 2'b10, 0, 0, 0);
        push("sb_wb_fwd", 0, 4'b0010, 0, 0, 1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        push("sb_count_hold", 0, 4'b0, 0, 0, 1);

        // Three bubbles with a two-cycle memory wait in the middle.
        do_reset();
        step();
        set_in(1, 6'o05, 2'b01, 6'o05, 2'b01, 1, 0, 0);
        push("mb_c0", 1, 4'b0001, 1, 0, 0);
        step();
        set_in(1, 6'o05, 2'b01, 6'o05, 2'b01, 1, 1, 0);
        push("mb_c1", 1, 4'b0001, 0, 1, 1);
        step();
        push("mb_c2", 1, 4'b0001, 0, 1, 2);
        step();
        set_in(1, 6'o05, 2'b01, 6'o05, 2'b01, 1, 1, 1);
        push("mb_c3", 1, 4'b0001, 1, 0, 3);
        step();
        set_in(1, 6'o05, 2'b01, 6'o05, 2'b01, 1, 0, 0);
        push("mb_c4", 1, 4'b0001, 1, 0, 4);
        step();
        set_in(1, 6'o05, 2'b01, 6'o50, 2'b10, 0, 0, 0);
        push("mb_c5", 1, 4'b0010, 0, 0, 5);

        // Hazard and memory wait together: wait first, bubble after the response.
        do_reset();
        for (int j = 0; j < 4; j++) begin
            step();
            set_in(1, 6'o05, 2'b01, 6'o05, 2'b01, 1, 1, 0);
            push($sformatf("sim_wait%0d", j), 0, 4'b0001, 0, 1, j);
        end
        step();
        set_in(1, 6'o05, 2'b01, 6'o05, 2'b01, 1, 1, 1);
        push("sim_release", 0, 4'b0001, 1, 0, 4);
        step();
        set_in(1, 6'o05, 2'b01, 6'o50, 2'b10, 0, 0, 0);
        push("sim_after", 0, 4'b0010, 0, 0, 5);

        // Asynchronous reset in the middle of a bubble sequence.
        do_reset();
        step();
        set_in(1, 6'o05, 2'b01, 6'o05, 2'b01, 1, 0, 0);
        push("rb_detect", 1, 4'b0001, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        push("rb_bubble", 1, 4'b0, 1, 0, 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rb_async_stall_load", {31'b0, stall_load_b}, 32'd0);
        check("rb_async_count", {16'b0, stall_count_b}, 32'd0);
        step();
        rst = 1'b0;
        push("rb_post0", 1, 4'b0, 0, 0, 0);
        step();
        push("rb_post1", 1, 4'b0, 0, 0, 0);
        step();
        set_in(1, 6'o05, 2'b01, 6'o05, 2'b01, 1, 0, 0);
        push("rb_redetect", 1, 4'b0001, 1, 0, 0);

        // Saturation of the 4-bit counter under a long memory wait.
        do_reset();
        for (int j = 0; j < 20; j++) begin
            step();
            set_in(0, 0, 0, 0, 0, 0, 1, 0);
            push($sformatf("sat_cyc%0d", j), 2, 4'b0, 0, 1, (j < 15) ? j : 15);
        end
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        push("sat_final", 2, 4'b0, 0, 0, 15);

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined LC-3b datapath. It sits beside the EX stage and compares the source registers of the EX instruction against the destinations of up to `NUM_FWD` downstream stages to produce per-operand forwarding selects. It also generates load-use bubbles with a configurable bubble count, freezes the pipeline while a data-memory access waits for `mem_resp`, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- `NUM_SRC`, 2: number of EX source operands checked.
- `REG_W`, 3: register-number width.
- `NUM_FWD`, 2: forwarding stages. Stage 1 is MEM, stage 2 is WB, and higher numbers are older.
- `LOAD_BUBBLES`, 1: bubbles inserted per load-use hazard. Must be at least 1.
- `CNT_W`, 16: width of the stall counter.
- `SEL_W`, $clog2(NUM_FWD+1): width of each forwarding select. Derived; do not override.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  EX holds a real instruction, not a bubble.
- `ex_src`  in  NUM_SRC*REG_W  source registers; operand i is at `[i*REG_W +: REG_W]`.
- `ex_src_valid`  in  NUM_SRC  operand i is actually read.
- `fwd_dest`  in  NUM_FWD*REG_W  destination register of stage k, at `[(k-1)*REG_W +: REG_W]`.
- `fwd_load`  in  NUM_FWD  stage k will write the regfile.
- `mem_read_mem`  in  1  stage-1 (MEM) instruction is a load.
- `mem_access`  in  1  stage-1 instruction is accessing data memory (read or write).
- `mem_resp`  in  1  data memory has completed the access this cycle.
- `fwd_sel`  out  NUM_SRC*SEL_W  per-operand select. 0 means use the regfile; k means forward from stage k.
- `stall_load`  out  1  hold IF/ID/EX and inject a bubble into MEM.
- `stall_mem`  out  1  freeze the entire pipeline.
- `stall_count`  out  CNT_W  saturating count of stall cycles.

## Operation
Forwarding (combinational):
- For operand i, `fwd_sel` is the smallest k such that `ex_src_valid[i]`, `fwd_load[k-1]`, and `ex_src[i] == fwd_dest[k-1]` all hold.
- If no stage matches, `fwd_sel` is 0.
- The youngest stage wins on multiple matches.
- `fwd_sel` is independent of `ex_valid` and of the stall state.

Memory wait:
- `stall_mem = mem_access & ~mem_resp`, combinational.
- `stall_mem` takes priority over everything else.

Load-use detection:
- `luh = ex_valid & mem_read_mem & fwd_load[0] & (some i: ex_src_valid[i] & ex_src[i] == fwd_dest[0])`.

State machine (states RUN, BUBBLE; bubble counter `bcnt`, width $clog2(LOAD_BUBBLES+1)):
- RUN:
  - `stall_load = luh & ~stall_mem`.
  - If `stall_load`: with `LOAD_BUBBLES == 1`, stay in RUN; otherwise go to BUBBLE with `bcnt = LOAD_BUBBLES-1`.
- BUBBLE:
  - `stall_load = ~stall_mem`.
  - When `stall_mem` is 0: decrement `bcnt`; on the cycle `bcnt == 1`, go to RUN.
  - When `stall_mem` is 1: `bcnt` and state are frozen.
  - No new detection is made in BUBBLE.

Stall counter:
- `stall_count` increments by 1 on every edge where `stall_load | stall_mem`.
- It saturates at 2^CNT_W-1 and never wraps.

## Timing
- Reset values: state RUN, `bcnt` 0, `stall_count` 0.
- While `rst` is high, `stall_load` and `stall_mem` are forced to 0. `fwd_sel` remains combinational.
- Reset asserted mid-BUBBLE returns the block to RUN immediately (asynchronously). No residual bubble follows reset release.
- `fwd_sel`, `stall_mem`, and the RUN-state `stall_load` have zero-cycle latency from their inputs.
- A load-use hazard produces exactly `LOAD_BUBBLES` cycles with `stall_load = 1`, not counting interleaved `stall_mem` cycles. The first bubble cycle is the detection cycle.
- Hazard and memory wait in the same cycle:
  - Only `stall_mem` is asserted.
  - Detection repeats after `mem_resp`, since EX and MEM are frozen.
- During a stall, `fwd_sel` may already point at stage 1 for a load. The datapath ignores it because `stall_load` holds EX.
- `mem_access` with `mem_resp` already high in the same cycle gives `stall_mem = 0` (single-cycle access).
- `stall_count` updates one edge after the stall cycle is seen.

## Test plan
- **Forwarding priority.** `NUM_FWD=2`, `ex_src={3,3}`, `fwd_dest={3,3}`, `fwd_load=2'b11`, all valids 1 -> both `fwd_sel = 1`. Clear `fwd_load[0]` -> both 2. Clear `ex_src_valid[1]` -> operand 1 is 0.
- **Single bubble.** `LOAD_BUBBLES=1`, load in MEM writing R5, EX reads R5 -> `stall_load = 1` for exactly one cycle. Next cycle with the load in WB -> `fwd_sel = 2` and `stall_load = 0`. `stall_count` = 1.
- **Multi-bubble with memory wait.** `LOAD_BUBBLES=3`, hazard, then `mem_access=1` / `mem_resp=0` for 2 cycles during BUBBLE -> `stall_load` pattern 1,0,0,1,1 and `stall_mem` pattern 0,1,1,0,0. `stall_count` = 5.
- **Simultaneous hazard and memory wait.** Hazard plus `mem_access=1`, `mem_resp=0` for 4 cycles, then `mem_resp=1` -> `stall_mem` is 1 for 4 cycles with `stall_load = 0`. Then `stall_load` is 1 for one cycle.
- **Reset mid-operation.** `rst` pulsed mid-BUBBLE -> `stall_load` drops without waiting for a clock edge, state is RUN, `stall_count` is 0. No bubble after release unless `luh` holds.
- **Saturation.** `CNT_W=4`, hold `stall_mem` for 20 cycles -> `stall_count` stops at 15.
